// File: rtl/frame_split2_if.sv
// Stream bundle for frame_split2: one paired input stream (A and B samples
// sharing a single valid/ready) and two independent output streams.
//
// Handshake semantics on every stream: a beat transfers on a rising clk edge
// where valid and ready are both high. Once valid is raised it stays high,
// with data and last held stable, until that transfer; ready may be driven
// combinationally from downstream state.
//
// Sample data is carried as raw two's-complement bit vectors.
interface frame_split2_if #(
  parameter int ADW = 24,
  parameter int BDW = 18,
  parameter int FLW = 16
);
  // Frame control
  logic [FLW-1:0] frame_len;
  logic           frame_done;

  // Paired input stream
  logic [ADW-1:0] s_axis_atdata;
  logic [BDW-1:0] s_axis_btdata;
  logic           s_axis_tvalid;
  logic           s_axis_tready;

  // A output stream
  logic [ADW-1:0] m_axis_atdata;
  logic           m_axis_atvalid;
  logic           m_axis_atlast;
  logic           m_axis_atready;

  // B output stream
  logic [BDW-1:0] m_axis_btdata;
  logic           m_axis_btvalid;
  logic           m_axis_btlast;
  logic           m_axis_btready;

  // Debug view of the frame tracker (beat counter and latched length)
  logic [FLW-1:0] dbg_beat_cnt;
  logic [FLW-1:0] dbg_len;

  // Block side: consumes the paired stream, produces the split streams.
  modport slave (
    input  frame_len,
    input  s_axis_atdata,
    input  s_axis_btdata,
    input  s_axis_tvalid,
    output s_axis_tready,
    output m_axis_atdata,
    output m_axis_atvalid,
    output m_axis_atlast,
    input  m_axis_atready,
    output m_axis_btdata,
    output m_axis_btvalid,
    output m_axis_btlast,
    input  m_axis_btready,
    output frame_done,
    output dbg_beat_cnt,
    output dbg_len
  );

  // Environment side: drives the paired stream and the downstream readies.
  modport master (
    output frame_len,
    output s_axis_atdata,
    output s_axis_btdata,
    output s_axis_tvalid,
    input  s_axis_tready,
    input  m_axis_atdata,
    input  m_axis_atvalid,
    input  m_axis_atlast,
    output m_axis_atready,
    input  m_axis_btdata,
    input  m_axis_btvalid,
    input  m_axis_btlast,
    output m_axis_btready,
    input  frame_done,
    input  dbg_beat_cnt,
    input  dbg_len
  );
endinterface

// File: rtl/frame_split2.sv
// frame_split2: accepts A/B sample pairs on one stream and fans them out to
// two independently draining one-entry register slices. A beat counter tracks
// frame position so both outputs carry the same last marker, and frame_done
// pulses one cycle after the last beat of a frame is accepted.
module frame_split2 #(
  parameter int ADW = 24,
  parameter int BDW = 18,
  parameter int FLW = 16
) (
  input  logic          clk,
  input  logic          rst,   // asynchronous, active low
  frame_split2_if.slave bus
);

  // Output slice state
  logic [ADW-1:0] a_data_q;
  logic           a_valid_q;
  logic           a_last_q;
  logic [BDW-1:0] b_data_q;
  logic           b_valid_q;
  logic           b_last_q;

  // Frame tracking state
  logic [FLW-1:0] beat_cnt_q;
  logic [FLW-1:0] len_q;
  logic           done_q;

  // Combinational control
  logic           a_drain;
  logic           b_drain;
  logic           s_ready;
  logic           accept;
  logic [FLW-1:0] eff_len;
  logic           beat_last;

  // Handshake decode: a new pair is taken only when both slices are empty or
  // emptying this cycle, so A and B always load on the same edge.
  always_comb begin
    a_drain = a_valid_q && bus.m_axis_atready;
    b_drain = b_valid_q && bus.m_axis_btready;
    s_ready = (!a_valid_q || bus.m_axis_atready) &&
              (!b_valid_q || bus.m_axis_btready);
    accept  = bus.s_axis_tvalid && s_ready;
  end

  // Frame length in force for the current beat: the first beat of a frame
  // uses the live input (zero meaning one), later beats use the latched value
  // so mid-frame changes are ignored. The counter only reaches len-1, so a
  // length of all-ones never wraps before last.
  always_comb begin
    eff_len = len_q;
    if (beat_cnt_q == '0) begin
      eff_len = (bus.frame_len == '0) ? FLW'(1) : bus.frame_len;
    end
    beat_last = (beat_cnt_q == (eff_len - FLW'(1)));
  end

  // A slice: load on acceptance, clear valid once the downstream takes it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_data_q  <= '0;
      a_last_q  <= 1'b0;
      a_valid_q <= 1'b0;
    end else if (accept) begin
      a_data_q  <= bus.s_axis_atdata;
      a_last_q  <= beat_last;
      a_valid_q <= 1'b1;
    end else if (a_drain) begin
      a_valid_q <= 1'b0;
    end
  end

  // B slice: same as A, draining on its own ready.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_data_q  <= '0;
      b_last_q  <= 1'b0;
      b_valid_q <= 1'b0;
    end else if (accept) begin
      b_data_q  <= bus.s_axis_btdata;
      b_last_q  <= beat_last;
      b_valid_q <= 1'b1;
    end else if (b_drain) begin
      b_valid_q <= 1'b0;
    end
  end

  // Beat counter and length latch: advance per accepted pair, restart after
  // the last beat, capture the effective length on the first beat.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beat_cnt_q <= '0;
      len_q      <= '0;
    end else if (accept) begin
      if (beat_cnt_q == '0) begin
        len_q <= eff_len;
      end
      if (beat_last) begin
        beat_cnt_q <= '0;
      end else begin
        beat_cnt_q <= beat_cnt_q + FLW'(1);
      end
    end
  end

  // Registered end-of-frame pulse, high the cycle after the last beat is taken.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= 1'b0;
    end else begin
      done_q <= accept && beat_last;
    end
  end

  // Port drive
  assign bus.s_axis_tready  = s_ready;
  assign bus.m_axis_atdata  = a_data_q;
  assign bus.m_axis_atvalid = a_valid_q;
  assign bus.m_axis_atlast  = a_last_q;
  assign bus.m_axis_btdata  = b_data_q;
  assign bus.m_axis_btvalid = b_valid_q;
  assign bus.m_axis_btlast  = b_last_q;
  assign bus.frame_done     = done_q;
  assign bus.dbg_beat_cnt   = beat_cnt_q;
  assign bus.dbg_len        = len_q;

endmodule

// File: tb/tb_frame_split2.sv
// Directed and randomised bench for frame_split2. Inputs change 1ns after
// the rising edge; outputs and handshakes are sampled on the falling edge.
module tb_frame_split2;
  localparam int ADW = 24;
  localparam int BDW = 18;
  localparam int FLW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_split2_if #(.ADW(ADW), .BDW(BDW), .FLW(FLW)) bus ();

  frame_split2 #(.ADW(ADW), .BDW(BDW), .FLW(FLW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp    = 0;
  int n_err    = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [ADW:0] exp_a_q[$];
  logic [BDW:0] exp_b_q[$];
  bit cur_last;
  bit exp_done;
  bit rnd_done;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      exp_a_q.delete();
      exp_b_q.delete();
      exp_done = 1'b0;
    end else begin
      check("frame_done", bus.frame_done, exp_done);
      if (bus.frame_done) done_cnt++;
      if (bus.m_axis_atvalid && bus.m_axis_atready) begin
        check("a_qsz", exp_a_q.size() != 0, 1);
        if (exp_a_q.size() != 0)
          check("a_beat", {bus.m_axis_atlast, bus.m_axis_atdata}, exp_a_q.pop_front());
      end
      if (bus.m_axis_btvalid && bus.m_axis_btready) begin
        check("b_qsz", exp_b_q.size() != 0, 1);
        if (exp_b_q.size() != 0)
          check("b_beat", {bus.m_axis_btlast, bus.m_axis_btdata}, exp_b_q.pop_front());
      end
      exp_done = bus.s_axis_tvalid && bus.s_axis_tready && cur_last;
      if (bus.s_axis_tvalid && bus.s_axis_tready) begin
        exp_a_q.push_back({cur_last, bus.s_axis_atdata});
        exp_b_q.push_back({cur_last, bus.s_axis_btdata});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Present one pair and hold it until accepted; returns 1ns after that edge.
  task automatic send_pair(input int a, input int b, input int flen, input bit last);
    bit ok;
    ok = 1'b0;
    bus.s_axis_atdata = ADW'(a);
    bus.s_axis_btdata = BDW'(b);
    bus.frame_len     = FLW'(flen);
    bus.s_axis_tvalid = 1'b1;
    cur_last          = last;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk);
      if (bus.s_axis_tvalid && bus.s_axis_tready) ok = 1'b1;
    end
    check("send_acc", ok, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.s_axis_tvalid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    bus.s_axis_tvalid = 1'b0;
    for (int i = 0; i < 200 && (exp_a_q.size() != 0 || exp_b_q.size() != 0); i++)
      @(posedge clk);
    @(posedge clk);
    #1;
    check("drain_a", exp_a_q.size(), 0);
    check("drain_b", exp_b_q.size(), 0);
  endtask

  task automatic set_ready(input bit ar, input bit br);
    bus.m_axis_atready = ar;
    bus.m_axis_btready = br;
  endtask

  // ---------------- stimulus ----------------
  int d0;
  int c0;
  logic [BDW-1:0] b_hold;
  int t4_a[6]    = '{1, 2, 3, 4, 5, 6};
  int t4_len[6]  = '{4, 4, 2, 2, 2, 2};
  bit t4_last[6] = '{0, 0, 0, 1, 0, 1};

  initial begin
    rst               = 1'b0;
    bus.frame_len     = '0;
    bus.s_axis_atdata = '0;
    bus.s_axis_btdata = '0;
    bus.s_axis_tvalid = 1'b0;
    set_ready(1'b0, 1'b0);
    cur_last = 1'b0;
    rnd_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    check("rst_atvalid", bus.m_axis_atvalid, 0);
    check("rst_btvalid", bus.m_axis_btvalid, 0);
    check("rst_atlast", bus.m_axis_atlast, 0);
    check("rst_btlast", bus.m_axis_btlast, 0);
    check("rst_atdata", bus.m_axis_atdata, 0);
    check("rst_btdata", bus.m_axis_btdata, 0);
    check("rst_done", bus.frame_done, 0);
    check("rst_tready", bus.s_axis_tready, 1);
    check("rst_cnt", bus.dbg_beat_cnt, 0);
    check("rst_len", bus.dbg_len, 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // T1: frame_len 4, full throughput, 8 pairs
    set_ready(1'b1, 1'b1);
    d0 = done_cnt;
    c0 = cyc;
    for (int i = 1; i <= 8; i++) send_pair(i, -i, 4, (i % 4) == 0);
    check("t1_cycles", cyc - c0, 8);
    drain();
    check("t1_done", done_cnt - d0, 2);

    // T2: frame_len 3, B stalled for 5 cycles
    set_ready(1'b1, 1'b0);
    d0 = done_cnt;
    b_hold = BDW'(-21);
    fork
      begin
        for (int i = 1; i <= 6; i++) send_pair(20 + i, -(20 + i), 3, (i % 3) == 0);
      end
      begin
        @(negedge clk);
        repeat (4) begin
          @(negedge clk);
          check("t2_tready", bus.s_axis_tready, 0);
          check("t2_bvalid", bus.m_axis_btvalid, 1);
          check("t2_bdata", bus.m_axis_btdata, b_hold);
        end
        @(posedge clk);
        #1;
        bus.m_axis_btready = 1'b1;
      end
    join
    drain();
    check("t2_done", done_cnt - d0, 2);

    // T3: frame_len 0 behaves as 1
    set_ready(1'b1, 1'b1);
    d0 = done_cnt;
    for (int i = 1; i <= 4; i++) send_pair(7 * i, -7 * i, 0, 1'b1);
    drain();
    check("t3_done", done_cnt - d0, 4);

    // T4: frame_len changed 4 -> 2 mid-frame
    d0 = done_cnt;
    for (int i = 0; i < 6; i++) send_pair(t4_a[i], -t4_a[i], t4_len[i], t4_last[i]);
    drain();
    check("t4_done", done_cnt - d0, 2);

    // T5: reset mid-frame with data pending
    set_ready(1'b0, 1'b0);
    send_pair(100, -100, 3, 1'b0);
    bus.s_axis_tvalid = 1'b0;
    check("t5_pend", bus.m_axis_atvalid, 1);
    rst = 1'b0;
    #1;
    check("t5_atvalid", bus.m_axis_atvalid, 0);
    check("t5_btvalid", bus.m_axis_btvalid, 0);
    check("t5_tready", bus.s_axis_tready, 1);
    check("t5_atdata", bus.m_axis_atdata, 0);
    check("t5_cnt", bus.dbg_beat_cnt, 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    set_ready(1'b1, 1'b1);
    d0 = done_cnt;
    for (int i = 1; i <= 3; i++) send_pair(100 + i, -(100 + i), 3, i == 3);
    drain();
    check("t5_done", done_cnt - d0, 1);

    // T6: random valid/ready, 1000 pairs, frame_len 5
    d0 = done_cnt;
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
          send_pair(int'($urandom), int'($urandom), 5, (i % 5) == 4);
        end
        bus.s_axis_tvalid = 1'b0;
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          set_ready(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
          @(posedge clk);
          #1;
        end
        set_ready(1'b1, 1'b1);
      end
    join
    drain();
    check("t6_done", done_cnt - d0, 200);

    // ---------------- report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
